// File: rtl/rename_table_ckpt.sv
// Register renamer: speculative RAT, committed CRAT and an allocated-register bitvector.
// One rename per cycle, in-order retire frees the superseded mapping, flush restores RAT from CRAT.
module rename_table_ckpt #(
  parameter int ARCH_REGS = 8,
  parameter int PHYS_REGS = 16,
  parameter int NUM_SRC   = 2,
  parameter int AW        = $clog2(ARCH_REGS),
  parameter int PW        = $clog2(PHYS_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ren_valid,
  output logic                   ren_ready,
  input  logic [NUM_SRC-1:0]     ren_src_ena,
  input  logic [NUM_SRC*AW-1:0]  ren_src_arch,
  input  logic                   ren_dst_ena,
  input  logic [AW-1:0]          ren_dst_arch,
  output logic [NUM_SRC*PW-1:0]  ren_src_phys,
  output logic [PW-1:0]          ren_dst_phys,
  output logic [PW-1:0]          ren_old_phys,
  input  logic                   retire_valid,
  input  logic [AW-1:0]          retire_arch,
  input  logic [PW-1:0]          retire_phys,
  input  logic                   flush,
  output logic [PW:0]            free_count
);

  logic [ARCH_REGS-1:0][PW-1:0] rat_q, rat_d;
  logic [ARCH_REGS-1:0][PW-1:0] crat_q, crat_d;
  logic [PHYS_REGS-1:0]         alloc_q, alloc_d;
  logic [PW-1:0]                free_idx;
  logic [PW:0]                  used_cnt;
  logic                         fire;

  // Downward scan so the lowest free index is the last one written.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
    free_idx = '0;
    used_cnt = '0;
    for (int i = PHYS_REGS - 1; i >= 0; i--) begin
      if (!alloc_q[i]) free_idx = PW'(i);
      used_cnt = used_cnt + (PW+1)'(alloc_q[i]);
    end
  end

  assign free_count = (PW+1)'(PHYS_REGS) - used_cnt;
  assign ren_ready  = !flush && (!ren_dst_ena || free_count != '0);
  assign fire       = ren_valid && ren_ready;

  // Lookups read the pre-write RAT, so a source naming its own destination sees the old mapping.
  always_comb begin
    ren_src_phys = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (ren_src_ena[s]) ren_src_phys[s*PW +: PW] = rat_q[ren_src_arch[s*AW +: AW]];
    end
    ren_dst_phys = ren_dst_ena ? free_idx : '0;
    ren_old_phys = ren_dst_ena ? rat_q[ren_dst_arch] : '0;
  end

  always_comb begin
    // NOTE: blocking '=' here lets later statements (flush rebuild) see the retire update made above.
    rat_d   = rat_q;
    crat_d  = crat_q;
    alloc_d = alloc_q;
    if (retire_valid) begin
      if (crat_q[retire_arch] != retire_phys) alloc_d[crat_q[retire_arch]] = 1'b0;
      crat_d[retire_arch] = retire_phys;
    end
    if (flush) begin
      rat_d   = crat_d;
      alloc_d = '0;
      for (int i = 0; i < ARCH_REGS; i++) alloc_d[crat_d[i]] = 1'b1;
    end else if (fire && ren_dst_ena) begin
      alloc_d[free_idx]     = 1'b1;
      rat_d[ren_dst_arch]   = free_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the map tables are reset flop arrays, not RAM, because the identity map must exist right after reset.
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat_q[i]  <= PW'(i);
        crat_q[i] <= PW'(i);
      end
      alloc_q <= {{(PHYS_REGS-ARCH_REGS){1'b0}}, {ARCH_REGS{1'b1}}};
    end else begin
      // NOTE: non-blocking '<=' for all state so every flop samples pre-edge values.
      rat_q   <= rat_d;
      crat_q  <= crat_d;
      alloc_q <= alloc_d;
    end
  end

endmodule

// File: tb/tb_rename_table_ckpt.sv
// Self-checking bench for rename_table_ckpt: directed vector table, hand-written
// flush/retire/reset sequences, then random traffic against an in-order ROB model.
module tb_rename_table_ckpt;

  localparam int ARCH_REGS = 8;
  localparam int PHYS_REGS = 16;
  localparam int NUM_SRC   = 2;
  localparam int AW        = 3;
  localparam int PW        = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  ren_valid;
  logic                  ren_ready;
  logic [NUM_SRC-1:0]    ren_src_ena;
  logic [NUM_SRC*AW-1:0] ren_src_arch;
  logic                  ren_dst_ena;
  logic [AW-1:0]         ren_dst_arch;
  logic [NUM_SRC*PW-1:0] ren_src_phys;
  logic [PW-1:0]         ren_dst_phys;
  logic [PW-1:0]         ren_old_phys;
  logic                  retire_valid;
  logic [AW-1:0]         retire_arch;
  logic [PW-1:0]         retire_phys;
  logic                  flush;
  logic [PW:0]           free_count;

  rename_table_ckpt #(
    .ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS), .NUM_SRC(NUM_SRC)
  ) dut (
    .clk(clk), .rst(rst),
    .ren_valid(ren_valid), .ren_ready(ren_ready),
    .ren_src_ena(ren_src_ena), .ren_src_arch(ren_src_arch),
    .ren_dst_ena(ren_dst_ena), .ren_dst_arch(ren_dst_arch),
    .ren_src_phys(ren_src_phys), .ren_dst_phys(ren_dst_phys), .ren_old_phys(ren_old_phys),
    .retire_valid(retire_valid), .retire_arch(retire_arch), .retire_phys(retire_phys),
    .flush(flush), .free_count(free_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input bit [1:0] se, input int s0, input int s1,
                       input bit de, input int d, input bit rv, input int ra, input int rp,
                       input bit fl);
    ren_valid    = v;
    ren_src_ena  = se;
    ren_src_arch = {AW'(s1), AW'(s0)};
    ren_dst_ena  = de;
    ren_dst_arch = AW'(d);
    retire_valid = rv;
    retire_arch  = AW'(ra);
    retire_phys  = PW'(rp);
    flush        = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("reset_free_count", 32'(free_count), 32'(PHYS_REGS - ARCH_REGS));
    rst = 1'b1;
  endtask

  function automatic int src_out(input int s);
    return int'(ren_src_phys[s*PW +: PW]);
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    string   name;
    bit      valid;
    bit [1:0] src_ena;
    int      s0, s1;
    bit      dst_ena;
    int      dst;
    bit      rv;
    int      ra, rp;
    bit      fl;
    bit      e_ready;
    int      e_s0, e_s1, e_dst, e_old, e_free;
    bit      chk_dst;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string n, input bit [1:0] se, input int s0, input int s1,
                         input bit de, input int d, input bit rv, input int ra, input int rp,
                         input bit er, input int es0, input int es1, input int edst,
                         input int eold, input int efree, input bit cd);
    vec_t v;
    v.name = n; v.valid = 1'b1; v.src_ena = se; v.s0 = s0; v.s1 = s1;
    v.dst_ena = de; v.dst = d; v.rv = rv; v.ra = ra; v.rp = rp; v.fl = 1'b0;
    v.e_ready = er; v.e_s0 = es0; v.e_s1 = es1; v.e_dst = edst; v.e_old = eold;
    v.e_free = efree; v.chk_dst = cd;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int arch; int phys; } rob_t;
  int   m_rat[ARCH_REGS];
  int   m_crat[ARCH_REGS];
  bit   m_used[PHYS_REGS];
  rob_t rob[$];

  function automatic void m_reset();
    for (int i = 0; i < ARCH_REGS; i++) begin
      m_rat[i] = i;
      m_crat[i] = i;
    end
    for (int p = 0; p < PHYS_REGS; p++) m_used[p] = (p < ARCH_REGS);
    rob.delete();
  endfunction

  function automatic int m_free();
    int n = 0;
    foreach (m_used[p]) if (!m_used[p]) n++;
    return n;
  endfunction

  function automatic int m_lowest();
    foreach (m_used[p]) if (!m_used[p]) return p;
    return -1;
  endfunction

  initial begin
    int  low, s0, s1, d, ra, rp, old;
    bit  v, de, rv, fl, exp_ready;
    bit [1:0] se;

    // ---- table: rename, exhaust, no-dst still fires, retire frees next cycle ----
    add_vec("ren_r3",       2'b11, 1, 3, 1, 3, 0, 0, 0, 1, 1, 3,  8,  3, 8, 1);
    add_vec("ren_r0_src_r3",2'b01, 3, 0, 1, 0, 0, 0, 0, 1, 8, 0,  9,  0, 7, 1);
    add_vec("ren_r1",       2'b00, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 10,  1, 6, 1);
    add_vec("ren_r2",       2'b00, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0, 11,  2, 5, 1);
    add_vec("ren_r4",       2'b00, 0, 0, 1, 4, 0, 0, 0, 1, 0, 0, 12,  4, 4, 1);
    add_vec("ren_r5",       2'b00, 0, 0, 1, 5, 0, 0, 0, 1, 0, 0, 13,  5, 3, 1);
    add_vec("ren_r6",       2'b00, 0, 0, 1, 6, 0, 0, 0, 1, 0, 0, 14,  6, 2, 1);
    add_vec("ren_r7",       2'b00, 0, 0, 1, 7, 0, 0, 0, 1, 0, 0, 15,  7, 1, 1);
    add_vec("full_dst",     2'b00, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0,  0,  8, 0, 0);
    add_vec("full_nodst",   2'b01, 7, 0, 0, 0, 0, 0, 0, 1, 15, 0, 0,  0, 0, 1);
    add_vec("retire_same",  2'b00, 0, 0, 1, 5, 1, 3, 8, 0, 0, 0,  0, 13, 0, 0);
    add_vec("after_retire", 2'b00, 0, 0, 1, 5, 0, 0, 0, 1, 0, 0,  3, 13, 1, 1);
    add_vec("empty_again",  2'b01, 5, 0, 0, 0, 0, 0, 0, 1, 3, 0,  0,  0, 0, 1);

    do_reset();
    foreach (vecs[k]) begin
      drive(vecs[k].valid, vecs[k].src_ena, vecs[k].s0, vecs[k].s1, vecs[k].dst_ena,
            vecs[k].dst, vecs[k].rv, vecs[k].ra, vecs[k].rp, vecs[k].fl);
      #2;
      check({vecs[k].name, ".ready"}, 32'(ren_ready), 32'(vecs[k].e_ready));
      check({vecs[k].name, ".free"},  32'(free_count), 32'(vecs[k].e_free));
      check({vecs[k].name, ".src0"},  32'(src_out(0)), 32'(vecs[k].e_s0));
      check({vecs[k].name, ".src1"},  32'(src_out(1)), 32'(vecs[k].e_s1));
      check({vecs[k].name, ".old"},   32'(ren_old_phys), 32'(vecs[k].e_old));
      if (vecs[k].chk_dst) check({vecs[k].name, ".dst"}, 32'(ren_dst_phys), 32'(vecs[k].e_dst));
      tick();
    end

    // ---- retire then flush: RAT restored from CRAT ----
    do_reset();
    drive(1, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0); #2;
    check("fl_ren_r1.dst", 32'(ren_dst_phys), 32'd8); tick();
    drive(1, 2'b00, 0, 0, 1, 2, 0, 0, 0, 0); #2;
    check("fl_ren_r2.dst", 32'(ren_dst_phys), 32'd9); tick();
    drive(0, 2'b00, 0, 0, 0, 0, 1, 1, 8, 0); tick();
    drive(1, 2'b00, 0, 0, 1, 3, 0, 0, 0, 1); #2;
    check("fl_blocks_ready", 32'(ren_ready), 32'd0); tick();
    drive(1, 2'b11, 1, 2, 1, 4, 0, 0, 0, 0); #2;
    check("fl_rat_r1", 32'(src_out(0)), 32'd8);
    check("fl_rat_r2", 32'(src_out(1)), 32'd2);
    check("fl_free",   32'(free_count), 32'd8);
    check("fl_alloc",  32'(ren_dst_phys), 32'd1);
    tick();

    // ---- retire and flush in the same cycle ----
    do_reset();
    drive(1, 2'b00, 0, 0, 1, 1, 0, 0, 0, 0); tick();
    drive(1, 2'b00, 0, 0, 1, 2, 0, 0, 0, 0); #2;
    check("rf_ren_r2.dst", 32'(ren_dst_phys), 32'd9); tick();
    drive(0, 2'b00, 0, 0, 0, 0, 1, 2, 9, 1); tick();
    drive(1, 2'b11, 2, 1, 1, 6, 0, 0, 0, 0); #2;
    check("rf_rat_r2", 32'(src_out(0)), 32'd9);
    check("rf_rat_r1", 32'(src_out(1)), 32'd1);
    check("rf_free",   32'(free_count), 32'd8);
    check("rf_alloc",  32'(ren_dst_phys), 32'd2);
    tick();

    // ---- asynchronous reset mid-burst ----
    do_reset();
    drive(1, 2'b00, 0, 0, 1, 3, 0, 0, 0, 0); tick();
    drive(1, 2'b00, 0, 0, 1, 4, 0, 0, 0, 0); tick();
    drive(1, 2'b00, 0, 0, 1, 5, 0, 0, 0, 0); tick();
    drive(1, 2'b01, 3, 0, 1, 6, 0, 0, 0, 0);
    #1 rst = 1'b0;
    #1;
    check("ar_free",  32'(free_count), 32'd8);
    check("ar_src_r3",32'(src_out(0)), 32'd3);
    check("ar_dst",   32'(ren_dst_phys), 32'd8);
    check("ar_old",   32'(ren_old_phys), 32'd6);
    check("ar_ready", 32'(ren_ready), 32'd1);
    ren_valid = 1'b0;
    #1 rst = 1'b1;
    tick();
    check("ar_free_after", 32'(free_count), 32'd8);

    // ---- random traffic vs. model with in-order retirement ----
    do_reset();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      v  = ($urandom_range(0, 9) < 7);
      de = ($urandom_range(0, 9) < 6);
      se = 2'($urandom_range(0, 3));
      s0 = $urandom_range(0, ARCH_REGS - 1);
      s1 = $urandom_range(0, ARCH_REGS - 1);
      d  = $urandom_range(0, ARCH_REGS - 1);
      fl = ($urandom_range(0, 99) < 3);
      rv = 1'b0; ra = 0; rp = 0;
      if (rob.size() > 0 && $urandom_range(0, 9) < 4) begin
        rv = 1'b1; ra = rob[0].arch; rp = rob[0].phys;
      end
      drive(v, se, s0, s1, de, d, rv, ra, rp, fl);
      #2;
      exp_ready = !fl && (!de || m_free() > 0);
      check("rnd.ready", 32'(ren_ready), 32'(exp_ready));
      check("rnd.free",  32'(free_count), 32'(m_free()));
      if (v) begin
        check("rnd.src0", 32'(src_out(0)), 32'(se[0] ? m_rat[s0] : 0));
        check("rnd.src1", 32'(src_out(1)), 32'(se[1] ? m_rat[s1] : 0));
        check("rnd.old",  32'(ren_old_phys), 32'(de ? m_rat[d] : 0));
        if (!de) check("rnd.dst_off", 32'(ren_dst_phys), 32'd0);
        else if (m_free() > 0) check("rnd.dst", 32'(ren_dst_phys), 32'(m_lowest()));
      end
      // model update for this edge
      low = m_lowest();
      if (rv) begin
        old = m_crat[ra];
        if (old != rp) m_used[old] = 1'b0;
        m_crat[ra] = rp;
        void'(rob.pop_front());
      end
      if (fl) begin
        foreach (m_used[p]) m_used[p] = 1'b0;
        for (int i = 0; i < ARCH_REGS; i++) begin
          m_rat[i] = m_crat[i];
          m_used[m_crat[i]] = 1'b1;
        end
        rob.delete();
      end else if (v && exp_ready && de) begin
        m_used[low] = 1'b1;
        m_rat[d] = low;
        rob.push_back('{arch: d, phys: low});
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
